// File: rtl/run_ctrl.sv
// Run sequencer and shared data-memory arbiter for the single-cycle 9-bit core.
// Optional single-step support is compiled in with `define RUN_CTRL_STEP_EN.
module run_ctrl #(
  parameter int unsigned D          = 10,
  parameter int unsigned AW         = 8,
  parameter int unsigned HALT_PC    = 128,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned CW         = 16,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  output logic          done,
  output logic          timeout,
  output logic          core_rst,
  output logic          core_en,
  input  logic [D-1:0]  prog_ctr,
  output logic [CW-1:0] cycle_cnt,
  output logic          host_grant,
  input  logic          host_wr_en,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_din,
  input  logic          core_wr_en,
  input  logic [AW-1:0] core_addr,
  input  logic [7:0]    core_din,
`ifdef RUN_CTRL_STEP_EN
  input  logic          step_mode,
  input  logic          step,
`endif
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din
);

  localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [CW-1:0]   cnt_d;
  logic            done_d, timeout_d, core_rst_d;
  logic            halt_c, step_ok_c;

  assign halt_c = (prog_ctr == D'(HALT_PC));

`ifdef RUN_CTRL_STEP_EN
  assign step_ok_c = ~step_mode | step;
`else
  assign step_ok_c = 1'b1;
`endif

  // The core never executes at HALT_PC, so the halting edge does not count.
  assign core_en    = (state_q == S_RUN) && step_ok_c && !halt_c;
  assign host_grant = (state_q == S_IDLE) || (state_q == S_DONE);

  // Memory port mux: granted side drives, the other side's writes are dropped.
  assign mem_wr_en = host_grant ? host_wr_en : (core_wr_en & core_en);
  assign mem_addr  = host_grant ? host_addr  : core_addr;
  assign mem_din   = host_grant ? host_din   : core_din;

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cnt_d     = cycle_cnt;
    timeout_d = timeout;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d   = S_INIT;
          rst_cnt_d = '0;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      end
      S_INIT: begin
        if (rst_cnt_q == RW'(RST_CYCLES - 1)) state_d = S_RUN;
        else rst_cnt_d = rst_cnt_q + RW'(1);
      end
      S_RUN: begin
        if (core_en) cnt_d = cycle_cnt + CW'(1);
        if (halt_c) begin
          state_d = S_DONE;
        end else if (core_en && (cycle_cnt == CW'(TIMEOUT - 1))) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      S_DONE: begin
        if (!req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    done_d     = (state_d == S_DONE);
    core_rst_d = (state_d == S_IDLE) || (state_d == S_INIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rst_cnt_q <= '0;
      cycle_cnt <= '0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      core_rst  <= 1'b1;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      cycle_cnt <= cnt_d;
      done      <= done_d;
      timeout   <= timeout_d;
      core_rst  <= core_rst_d;
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: directed sequences, an arbitration vector
// table, and a randomized run against a run-phase reference model.
module tb_run_ctrl;
  localparam int unsigned D          = 10;
  localparam int unsigned AW         = 8;
  localparam int unsigned HALT_PC    = 128;
  localparam int unsigned RST_CYCLES = 2;
  localparam int unsigned CW         = 16;
  localparam int unsigned TIMEOUT    = 1000;

  logic          clk = 1'b0;
  logic          reset, req;
  logic          done, timeout, core_rst, core_en, host_grant;
  logic [D-1:0]  prog_ctr;
  logic [CW-1:0] cycle_cnt;
  logic          host_wr_en, core_wr_en, mem_wr_en;
  logic [AW-1:0] host_addr, core_addr, mem_addr;
  logic [7:0]    host_din, core_din, mem_din;
`ifdef RUN_CTRL_STEP_EN
  logic          step_mode, step;
`endif

  int total = 0;
  int bad   = 0;
  int pc    = 0;
  bit loop_mode = 1'b0;

  assign prog_ctr = D'(pc);

  always #5 clk = ~clk;

  run_ctrl #(.D(D), .AW(AW), .HALT_PC(HALT_PC), .RST_CYCLES(RST_CYCLES),
             .CW(CW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done), .timeout(timeout),
    .core_rst(core_rst), .core_en(core_en), .prog_ctr(prog_ctr),
    .cycle_cnt(cycle_cnt), .host_grant(host_grant), .host_wr_en(host_wr_en),
    .host_addr(host_addr), .host_din(host_din), .core_wr_en(core_wr_en),
    .core_addr(core_addr), .core_din(core_din),
`ifdef RUN_CTRL_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_din(mem_din));

  typedef struct packed {
    logic       in_run;
    logic       hw;
    logic [7:0] ha, hd;
    logic       cw;
    logic [7:0] ca, cd;
    logic       ew;
    logic [7:0] ea, ed;
  } vec_t;
  vec_t vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int next_pc(input int p);
    return loop_mode ? (p + 1) % 100 : p + 1;
  endfunction

  // Core model for directed tests: PC follows the DUT's reset/enable.
  task automatic tick();
    logic en, rs;
    en = core_en;
    rs = core_rst;
    @(posedge clk);
    @(negedge clk);
    if (rs) pc = 0;
    else if (en) pc = next_pc(pc);
  endtask

  task automatic start_run();
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (RST_CYCLES) tick();
  endtask

  task automatic wait_done(input int budget, input string name);
    for (int i = 0; i < budget && !done; i++) tick();
    chk({name, "_done"}, done, 1);
  endtask

  task automatic apply_vectors(input logic phase);
    for (int i = 0; i < 8; i++) begin
      if (vt[i].in_run == phase) begin
        host_wr_en = vt[i].hw; host_addr = vt[i].ha; host_din = vt[i].hd;
        core_wr_en = vt[i].cw; core_addr = vt[i].ca; core_din = vt[i].cd;
        #1;
        chk($sformatf("vec%0d_grant", i), host_grant, !vt[i].in_run);
        chk($sformatf("vec%0d_wr", i), mem_wr_en, vt[i].ew);
        chk($sformatf("vec%0d_addr", i), mem_addr, vt[i].ea);
        chk($sformatf("vec%0d_din", i), mem_din, vt[i].ed);
      end
    end
    host_wr_en = 0; host_addr = 0; host_din = 0;
    core_wr_en = 0; core_addr = 0; core_din = 0;
  endtask

  // Reference model: run phase tracked as idle/active/finished plus edges since start.
  int m_mode, m_age, m_cnt, m_to;

  function automatic bit m_running();
    return (m_mode == 1) && (m_age >= int'(RST_CYCLES));
  endfunction

  function automatic bit m_en();
    bit ok;
    ok = 1'b1;
`ifdef RUN_CTRL_STEP_EN
    ok = !step_mode || step;
`endif
    return m_running() && (pc != int'(HALT_PC)) && ok;
  endfunction

  task automatic model_step(input bit r, input bit q, input bit en, input bit rs, input bit run);
    int pc_pre;
    pc_pre = pc;
    if (rs) pc = 0;
    else if (en) pc = next_pc(pc);
    if (r) begin
      m_mode = 0; m_cnt = 0; m_to = 0;
    end else if (m_mode == 0) begin
      if (q) begin
        m_mode = 1; m_age = 0; m_cnt = 0; m_to = 0;
        loop_mode = ($urandom_range(0, 3) == 0);
      end
    end else if (m_mode == 1) begin
      m_age++;
      if (run) begin
        if (pc_pre == int'(HALT_PC)) m_mode = 2;
        else if (en) begin
          m_cnt++;
          if (m_cnt == int'(TIMEOUT)) begin m_mode = 2; m_to = 1; end
        end
      end
    end else if (!q) begin
      m_mode = 0;
    end
  endtask

  initial begin
    bit en, rs, run, gr;
    vt[0] = {1'b0, 1'b1, 8'h10, 8'hA5, 1'b0, 8'h33, 8'h11, 1'b1, 8'h10, 8'hA5};
    vt[1] = {1'b0, 1'b0, 8'h10, 8'hA5, 1'b1, 8'h33, 8'h11, 1'b0, 8'h10, 8'hA5};
    vt[2] = {1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 8'h01, 8'h02, 1'b1, 8'hFF, 8'h00};
    vt[3] = {1'b0, 1'b0, 8'h00, 8'h5A, 1'b0, 8'h77, 8'h88, 1'b0, 8'h00, 8'h5A};
    vt[4] = {1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 8'h33, 8'h11, 1'b0, 8'h33, 8'h11};
    vt[5] = {1'b1, 1'b1, 8'h10, 8'hA5, 1'b1, 8'h20, 8'hC3, 1'b1, 8'h20, 8'hC3};
    vt[6] = {1'b1, 1'b0, 8'h44, 8'h55, 1'b1, 8'hFE, 8'h01, 1'b1, 8'hFE, 8'h01};
    vt[7] = {1'b1, 1'b0, 8'h10, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00};

    reset = 1; req = 0;
    host_wr_en = 0; host_addr = 0; host_din = 0;
    core_wr_en = 0; core_addr = 0; core_din = 0;
`ifdef RUN_CTRL_STEP_EN
    step_mode = 0; step = 0;
`endif
    tick(); tick();
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_core_en", core_en, 0);
    chk("rst_cnt", cycle_cnt, 0);
    chk("rst_grant", host_grant, 1);
    reset = 0;
    tick();
    apply_vectors(1'b0);

    // Start latency and halt at HALT_PC.
    req = 1; tick(); req = 0;
    chk("init1_rst", core_rst, 1);
    chk("init1_en", core_en, 0);
    tick();
    chk("init2_rst", core_rst, 1);
    chk("init2_en", core_en, 0);
    tick();
    chk("run1_rst", core_rst, 0);
    chk("run1_en", core_en, 1);
    chk("run1_grant", host_grant, 0);
    apply_vectors(1'b1);
    wait_done(300, "halt");
    chk("halt_cnt", cycle_cnt, 128);
    chk("halt_to", timeout, 0);
    chk("halt_en", core_en, 0);
    chk("halt_grant", host_grant, 1);
    tick();
    chk("halt_idle_done", done, 0);
    chk("halt_idle_rst", core_rst, 1);

    // Timeout when the program loops below HALT_PC.
    loop_mode = 1;
    start_run();
    wait_done(1200, "tmo");
    chk("tmo_flag", timeout, 1);
    chk("tmo_cnt", cycle_cnt, TIMEOUT);
    chk("tmo_en", core_en, 0);
    tick();
    loop_mode = 0;

    // Reset in the middle of a run, then a clean rerun.
    start_run();
    repeat (50) tick();
    chk("mid_cnt", cycle_cnt, 50);
    reset = 1; tick(); reset = 0;
    chk("mid_rst_core_rst", core_rst, 1);
    chk("mid_rst_cnt", cycle_cnt, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_grant", host_grant, 1);
    start_run();
    chk("rerun_en", core_en, 1);
    chk("rerun_cnt0", cycle_cnt, 0);
    tick();
    chk("rerun_cnt1", cycle_cnt, 1);

    // req held high through DONE: no auto-restart.
    req = 1;
    wait_done(300, "hold");
    repeat (5) tick();
    chk("hold_done", done, 1);
    chk("hold_en", core_en, 0);
    chk("hold_cnt", cycle_cnt, 128);
    req = 0; tick();
    chk("hold_release_done", done, 0);
    chk("hold_release_rst", core_rst, 1);
    req = 1; tick(); req = 0;
    chk("second_cnt0", cycle_cnt, 0);
    chk("second_init", core_rst, 1);
    wait_done(300, "second");
    chk("second_cnt", cycle_cnt, 128);
    tick();

`ifdef RUN_CTRL_STEP_EN
    // Single-step: three pulses advance exactly three instructions.
    step_mode = 1; step = 0;
    start_run();
    repeat (4) tick();
    chk("step_idle_en", core_en, 0);
    chk("step_idle_cnt", cycle_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      step = 1; #1;
      chk("step_pulse_en", core_en, 1);
      tick();
      step = 0; #1;
      chk("step_gap_en", core_en, 0);
      tick();
    end
    chk("step_cnt", cycle_cnt, 3);
    step_mode = 0;
    wait_done(300, "step");
    chk("step_final_cnt", cycle_cnt, 128);
    tick();
`endif

    // Randomized run against the reference model.
    reset = 1; tick(); tick(); reset = 0;
    pc = 0; m_mode = 0; m_age = 0; m_cnt = 0; m_to = 0; loop_mode = 0;
    for (int c = 0; c < 15000; c++) begin
      reset      = ($urandom_range(0, 1999) == 0);
      req        = ($urandom_range(0, 3) != 0);
      host_wr_en = 1'($urandom); host_addr = 8'($urandom); host_din = 8'($urandom);
      core_wr_en = 1'($urandom); core_addr = 8'($urandom); core_din = 8'($urandom);
`ifdef RUN_CTRL_STEP_EN
      step_mode = ($urandom_range(0, 7) == 0);
      step      = 1'($urandom);
`endif
      #1;
      en  = m_en();
      run = m_running();
      rs  = (m_mode == 0) || (m_mode == 1 && !run);
      gr  = (m_mode != 1);
      chk("r_done", done, m_mode == 2);
      chk("r_timeout", timeout, m_to);
      chk("r_core_rst", core_rst, rs);
      chk("r_core_en", core_en, en);
      chk("r_cnt", cycle_cnt, m_cnt);
      chk("r_grant", host_grant, gr);
      chk("r_mem_wr", mem_wr_en, gr ? host_wr_en : (core_wr_en & en));
      chk("r_mem_addr", mem_addr, gr ? host_addr : core_addr);
      chk("r_mem_din", mem_din, gr ? host_din : core_din);
      @(posedge clk);
      @(negedge clk);
      model_step(reset, req, en, rs, run);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
